uart_tx_fifo_param: RTL

//   Parametrised UART transmitter: successor to the fixed 8E1 baud-clocked TX.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync_fifo.sv | 48 ++++
 rtl/uart_tx_fifo_param.sv | 106 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity constants, TX FSM encoding and frame-length helper shared by the UART blocks
package uart_pkg;
   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_e;

   function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
      return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
   endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with the head word always presented on o_data
//   i_clk/i_rst    clock, synchronous active-high reset (clears pointers)
//   i_push/i_data  write request and word; ignored while full
//   i_pop          read request; ignored while empty
//   o_data         current head word, valid whenever o_empty=0
//   o_full/o_empty status, o_level words stored
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_level
);
   localparam int AW = $clog2(DEPTH);

   // one extra pointer bit tells a full FIFO apart from an empty one
   logic [AW:0]      wr_q, rd_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push, pop;

   assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign o_empty = wr_q == rd_q;
   assign o_level = wr_q - rd_q;
   assign push    = i_push && !o_full;
   assign pop     = i_pop && !o_empty;
   assign o_data  = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= push ? wr_q + 1'b1 : wr_q;
         rd_q <= pop ? rd_q + 1'b1 : rd_q;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem_q[wr_q[AW-1:0]] <= i_data;
   end
endmodule

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: FIFO-fed UART transmitter with internal baud divider and configurable framing
//   i_clk/i_rst      system clock, synchronous active-high reset
//   i_data/i_valid   word to queue; accepted when i_valid & o_ready
//   o_ready          FIFO has room (low during reset)
//   o_level          words waiting in the FIFO, excluding the frame on the line
//   o_busy           frame on the line or words queued
//   o_line           serial output, idles high
module uart_tx_fifo_param
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = 434,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = PAR_EVEN,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [DATA_BITS-1:0]            i_data,
   input  logic                            i_valid,
   output logic                            o_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] o_level,
   output logic                            o_busy,
   output logic                            o_line
);
   localparam int DW = $clog2(CLK_DIV);
   localparam int BW = $clog2(DATA_BITS + 1);

   generate
      if ((CLK_DIV < 2) || (DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY < PAR_NONE) ||
          (PARITY > PAR_ODD) || (STOP_BITS < 1) || (STOP_BITS > 2) || (FIFO_DEPTH < 2) ||
          ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_params
         $error("uart_tx_fifo_param: parameter out of range");
      end
   endgenerate

   uart_state_e          state_q, state_d;
   logic [DW-1:0]        div_q;
   logic [BW-1:0]        cnt_q;
   logic [DATA_BITS-1:0] sh_q, head;
   logic                 par_q, line_q, busy_q;
   logic                 full, empty, pop, tick;

   assign o_ready = !i_rst && !full;
   assign tick    = div_q == DW'(CLK_DIV - 1);
   assign o_line  = line_q;
   assign o_busy  = busy_q;

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_valid && o_ready),
      .i_data  (i_data),
      .i_pop   (pop),
      .o_data  (head),
      .o_full  (full),
      .o_empty (empty),
      .o_level (o_level)
   );

   // the pop that ends the last stop bit jumps straight to START so frames stay contiguous
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            pop     = !empty;
            state_d = empty ? ST_IDLE : ST_START;
         end
         ST_START:  state_d = tick ? ST_DATA : ST_START;
         ST_DATA:   state_d = (tick && cnt_q == BW'(DATA_BITS - 1)) ?
                              ((PARITY != PAR_NONE) ? ST_PARITY : ST_STOP) : ST_DATA;
         ST_PARITY: state_d = tick ? ST_STOP : ST_PARITY;
         ST_STOP: begin
            if (tick && cnt_q == BW'(STOP_BITS - 1)) begin
               pop     = !empty;
               state_d = empty ? ST_IDLE : ST_START;
            end
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   // line and busy are registered from the current state, so each bit appears one clock after its state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         sh_q    <= '0;
         par_q   <= 1'b0;
         line_q  <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= (pop || tick || state_q == ST_IDLE) ? '0 : div_q + 1'b1;
         cnt_q   <= (state_d != state_q) ? '0 : tick ? cnt_q + 1'b1 : cnt_q;
         sh_q    <= pop ? head : (state_q == ST_DATA && tick) ? sh_q >> 1 : sh_q;
         par_q   <= pop ? ((PARITY == PAR_ODD) ? ~^head : ^head) : par_q;
         line_q  <= (state_q == ST_START) ? 1'b0 :
                    (state_q == ST_DATA) ? sh_q[0] :
                    (state_q == ST_PARITY) ? par_q : 1'b1;
         busy_q  <= (state_q != ST_IDLE) || !empty;
      end
   end
endmodule
